// File: rtl/serial_parity_framer.sv
// ---------------------------------------------------------------------------
// serial_parity_framer
//
// Purpose:
//   Collects a serial bit stream one bit per accepted transfer, keeps a
//   running XOR of the bits and emits one parity result per frame. A frame
//   closes on bit_last or once FRAME_LEN bits have been taken, whichever
//   happens first. Both sides use valid/ready handshakes. While a result is
//   waiting to be taken the input side is stalled, so each frame costs one
//   extra cycle.
//
// Parameters:
//   FRAME_LEN  maximum number of bits per frame (>= 1)
//   ODD        0 = even parity (plain XOR), 1 = odd parity (inverted XOR)
//   LW         width of par_len, wide enough to hold FRAME_LEN
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   bit_valid  bit_data / bit_last are valid this cycle
//   bit_data   serial data bit
//   bit_last   this bit closes the current frame
//   bit_ready  framer accepts a bit this cycle (state decode only)
//   par_valid  parity result available (state decode only)
//   par_data   parity of the completed frame
//   par_len    number of bits in the completed frame, 1..FRAME_LEN
//   par_ready  downstream accepts the result
// ---------------------------------------------------------------------------
module serial_parity_framer #(
    parameter int FRAME_LEN = 8,
    parameter bit ODD       = 1'b0,
    localparam int LW       = $clog2(FRAME_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bit_valid,
    input  logic          bit_data,
    input  logic          bit_last,
    output logic          bit_ready,
    output logic          par_valid,
    output logic          par_data,
    output logic [LW-1:0] par_len,
    input  logic          par_ready
);

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic            r_acc;
    logic [LW-1:0]   r_cnt;
    logic            r_parData;
    logic [LW-1:0]   r_parLen;

    logic            w_bitXfer;
    logic [LW-1:0]   w_cntNext;
    logic            w_frameEnd;

    // Handshake flags come straight from the state register so no input
    // ever reaches an output combinationally.
    assign bit_ready = (r_state == ST_ACC);
    assign par_valid = (r_state == ST_OUT);
    assign par_data  = r_parData;
    assign par_len   = r_parLen;

    // A bit lands in the current frame only while accumulating. The frame
    // closes on bit_last or when this bit is the FRAME_LEN-th one; both
    // together still close just one frame.
    assign w_bitXfer  = bit_valid && (r_state == ST_ACC);
    assign w_cntNext  = r_cnt + 1'b1;
    assign w_frameEnd = w_bitXfer && (bit_last || (w_cntNext == LW'(FRAME_LEN)));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic: leave ACC when a frame closes, return once the
    // result has been taken downstream.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_ACC: begin
                if (w_frameEnd) begin
                    w_stateNext = ST_OUT;
                end
            end
            ST_OUT: begin
                if (par_ready) begin
                    w_stateNext = ST_ACC;
                end
            end
            default: begin
                w_stateNext = ST_ACC;
            end
        endcase
    end

    // Accumulator, bit counter and the held result. At frame close the
    // closing bit is folded in directly so the result is ready on the very
    // next cycle, and the accumulator restarts clean for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= 1'b0;
            r_cnt     <= '0;
            r_parData <= 1'b0;
            r_parLen  <= '0;
        end else if (w_frameEnd) begin
            r_parData <= r_acc ^ bit_data ^ ODD;
            r_parLen  <= w_cntNext;
            r_acc     <= 1'b0;
            r_cnt     <= '0;
        end else if (w_bitXfer) begin
            r_acc     <= r_acc ^ bit_data;
            r_cnt     <= w_cntNext;
        end
    end

endmodule
